// File: rtl/tone_synth.sv
// Turns a note frequency into a 50% square wave; half-period = CLK_HZ/(2*f) via a CNT_W-cycle divider.
// Latency: half_period updates CNT_W edges after a change is sampled; no backpressure, latest value wins.
module tone_synth #(
   parameter int CLK_HZ   = 50_000_000,
   parameter int CNT_W    = 26,
   parameter int FREQ_W   = 11,
   parameter int MIN_FREQ = 20
) (
   input  logic              CP,
   input  logic              CR,
   input  logic [FREQ_W-1:0] frequency,
   input  logic              en,
   output logic              buzzer,
   output logic              note_on,
   output logic              busy,
   output logic [CNT_W-1:0]  half_period
);

   localparam logic [CNT_W-1:0]  DIVIDEND = CNT_W'(CLK_HZ / 2);
   localparam logic [FREQ_W-1:0] MIN_F    = FREQ_W'(MIN_FREQ);
   localparam int                BIT_W    = $clog2(CNT_W);
   localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(CNT_W - 1);

   typedef enum logic {S_IDLE, S_DIV} state_t;

   state_t             state_q, state_d;
   logic [FREQ_W-1:0]  freq_q, freq_d;
   logic [CNT_W-1:0]   rem_q, rem_d;
   logic [CNT_W-1:0]   quo_q, quo_d;
   logic [CNT_W-1:0]   dvsr_q, dvsr_d;
   logic [BIT_W-1:0]   bit_q, bit_d;
   logic [CNT_W-1:0]   half_q, half_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               buzz_q, buzz_d;
   logic               note_q, note_d;

   logic [CNT_W:0]     trial;
   logic               fits;
   logic [CNT_W-1:0]   step_rem;
   logic [CNT_W-1:0]   step_quo;

   always_ff @(posedge CP or posedge CR) begin
      if (CR) begin
         state_q <= S_IDLE;
         freq_q  <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvsr_q  <= '0;
         bit_q   <= '0;
         half_q  <= '0;
         cnt_q   <= '0;
         buzz_q  <= 1'b0;
         note_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         freq_q  <= freq_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvsr_q  <= dvsr_d;
         bit_q   <= bit_d;
         half_q  <= half_d;
         cnt_q   <= cnt_d;
         buzz_q  <= buzz_d;
         note_q  <= note_d;
      end
   end

   always_comb begin
      // Restoring step: quo_q shifts the dividend out MSB-first while quotient bits shift in.
      trial    = {rem_q, quo_q[CNT_W-1]};
      fits     = trial >= {1'b0, dvsr_q};
      step_rem = fits ? (trial[CNT_W-1:0] - dvsr_q) : trial[CNT_W-1:0];
      step_quo = {quo_q[CNT_W-2:0], fits};

      state_d = state_q;
      freq_d  = freq_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvsr_d  = dvsr_q;
      bit_d   = bit_q;
      half_d  = half_q;
      cnt_d   = cnt_q;
      buzz_d  = buzz_q;
      note_d  = note_q;

      if (note_q) begin
         if (cnt_q == half_q - CNT_W'(1)) begin
            cnt_d  = '0;
            buzz_d = ~buzz_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      if (!en) begin
         state_d = S_IDLE;
         freq_d  = '0;
         cnt_d   = '0;
         buzz_d  = 1'b0;
         note_d  = 1'b0;
      end else if (frequency != freq_q) begin
         freq_d = frequency;
         if (frequency >= MIN_F) begin
            state_d = S_DIV;
            rem_d   = '0;
            quo_d   = DIVIDEND;
            dvsr_d  = CNT_W'(frequency);
            bit_d   = '0;
         end else begin
            state_d = S_IDLE;
            half_d  = '0;
            cnt_d   = '0;
            buzz_d  = 1'b0;
            note_d  = 1'b0;
         end
      end else if (state_q == S_DIV) begin
         rem_d = step_rem;
         quo_d = step_quo;
         bit_d = bit_q + BIT_W'(1);
         if (bit_q == LAST_BIT) begin
            // Buzzer level is kept across the reload so the new tone starts without a runt pulse.
            state_d = S_IDLE;
            half_d  = step_quo;
            cnt_d   = '0;
            buzz_d  = buzz_q;
            note_d  = 1'b1;
         end
      end
   end

   assign buzzer      = buzz_q;
   assign note_on     = note_q;
   assign busy        = (state_q == S_DIV);
   assign half_period = half_q;

endmodule

// File: doc/tone_synth.md
Name: tone_synth

Overview:
- Converts the 11-bit note frequency (Hz) from the free-play / note-select stage into a square wave that drives the board buzzer.
- Computes the half-period count CLK_HZ/(2*frequency) once per note change with a multi-cycle sequential divider, then toggles the output from a free-running counter.
- Sits directly downstream of the key-to-frequency stage and directly upstream of the buzzer pin.
- Frequency codes below MIN_FREQ, including the silence code 1, mute the output.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency on CP, in Hz.
- CNT_W, 26, width of the divider and tone counter; 2^CNT_W must exceed CLK_HZ/2.
- FREQ_W, 11, width of the frequency input.
- MIN_FREQ, 20, lowest audible code; any frequency below this is silence.

Ports:
- CP  input  1  system clock; all state changes on the rising edge.
- CR  input  1  asynchronous, active-high reset.
- frequency  input  FREQ_W  requested tone in Hz; 1 = silence.
- en  input  1  play enable; 0 mutes the output.
- buzzer  output  1  square-wave output.
- note_on  output  1  high while a valid tone is being produced.
- busy  output  1  high while the divider is running.
- half_period  output  CNT_W  current half-period in CP cycles (debug).

Behaviour:
- Reset (CR=1, asynchronous): buzzer=0, note_on=0, busy=0, half_period=0. Internal freq_q=0, tone counter=0, divider state=IDLE.

Divider FSM, states IDLE and DIV:
- IDLE, en=1, frequency!=freq_q, frequency>=MIN_FREQ: latch freq_q<=frequency, load dividend CLK_HZ/2 and divisor, set busy=1, go to DIV.
- IDLE, en=1, frequency!=freq_q, frequency<MIN_FREQ: latch freq_q, note_on<=0, buzzer<=0, tone counter<=0, half_period<=0. Stay in IDLE; no division.
- DIV: restoring division, one quotient bit per cycle, exactly CNT_W cycles. On the last edge: half_period<=quotient (truncated), note_on<=1, tone counter<=0, busy<=0, go to IDLE.
- DIV latency: half_period is valid CNT_W edges after the edge that sampled the change.
- Change during DIV: if frequency!=freq_q on any DIV edge, restart immediately with the new value (latch it, reset the bit count). Latest value wins.
- Old tone during DIV: the previous tone keeps playing unchanged; a muted output stays muted.
- en=0, any state: next edge buzzer<=0, note_on<=0, tone counter<=0, freq_q<=0, busy<=0, state<=IDLE. Raising en again forces a recompute.

Tone counter (active when note_on=1):
- Increments every cycle.
- When count==half_period-1: count<=0 and buzzer toggles.
- Output period = 2*half_period cycles, duty 50%.
- New half_period load: count cleared, buzzer level preserved, so there is no runt pulse longer than the old half-period.
- First note out of silence: buzzer starts at 0 and first rises after half_period cycles.

Arithmetic:
- Quotient is truncated.
- Largest half_period is (CLK_HZ/2)/MIN_FREQ and fits in CNT_W.
- Divisor is never 0, because codes 0 and 1 are silence.

Reset mid-operation:
- Asserting CR during DIV or playback returns all state to reset values immediately.
- After release with frequency=1, the silence path latches freq_q=1 and the output stays muted.

Test Plan:
Bench overrides CLK_HZ=1_000_000 and CNT_W=20, giving dividend 500_000.
1. Reset, en=1, frequency=440 -> busy high for 20 cycles, then half_period=1136, note_on=1; buzzer period 2272 cycles, 50% duty.
2. Playing 440, switch to 523 -> old 1136-cycle toggling continues through DIV; then half_period=956; first new toggle 956 cycles after load, no short pulse.
3. frequency 262 then 294 on the 5th DIV cycle -> divider restarts; busy stays high for 20 cycles after the 294 change; final half_period=1700 (294), never 1908.
4. Playing 1977 (half_period=252), frequency->1 -> next edge buzzer=0, note_on=0, half_period=0, busy stays 0; back to 1977 recomputes 252.
5. Playing 659 (758), en=0 for 3 cycles then 1 -> buzzer held 0, note_on 0; after re-enable, DIV runs for 20 cycles and half_period=758 again.
6. CR pulsed mid-DIV for 880 -> all outputs 0 asynchronously; after release with frequency=880, a full 20-cycle DIV runs and half_period=568.
